// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: condition-checked ALU result register with flag update,
// skip counter and a 2-entry skid buffer feeding register-file writeback.
module alu_writeback_stage #(
   parameter int WIDTH = 32,
   parameter int RD_W  = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [3:0]       in_flags,
   input  logic [RD_W-1:0]  in_rd,
   input  logic             in_set_flags,
   input  logic [3:0]       in_cond,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [RD_W-1:0]  out_rd,
   output logic [3:0]       flags_q,
   output logic [CNT_W-1:0] skip_count
);
   logic             main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic [WIDTH-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic [RD_W-1:0]  main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
   logic [3:0]       flags_d;
   logic [CNT_W-1:0] skip_q, skip_d;
   logic             n, z, c, v, pass, accept, enq;
   logic [7:0]       even_pass;
   assign {n, z, c, v} = flags_q;
   // each odd condition code is the negation of the even code below it
   assign even_pass = {1'b1, ~z & (n == v), n == v, c & ~z, v, n, c, z};
   assign pass      = even_pass[in_cond[3:1]] ^ in_cond[0];
   assign in_ready  = ~skid_v_q;
   assign accept    = in_valid & in_ready;
   assign enq       = accept & pass;
   assign out_valid  = main_v_q;
   assign out_data   = main_data_q;
   assign out_rd     = main_rd_q;
   assign skip_count = skip_q;
   assign flags_d = (enq & in_set_flags) ? in_flags : flags_q;
   assign skip_d  = (accept & ~pass & ~&skip_q) ? skip_q + 1'b1 : skip_q;
   always_comb begin
      main_v_d    = main_v_q;
      main_data_d = main_data_q;
      main_rd_d   = main_rd_q;
      skid_v_d    = skid_v_q;
      skid_data_d = skid_data_q;
      skid_rd_d   = skid_rd_q;
      if (flush) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (skid_v_q) begin
         if (out_ready) begin
            main_v_d    = 1'b1;
            main_data_d = skid_data_q;
            main_rd_d   = skid_rd_q;
            skid_v_d    = 1'b0;
         end
      end else if (main_v_q & ~out_ready) begin
         if (enq) begin
            skid_v_d    = 1'b1;
            skid_data_d = in_data;
            skid_rd_d   = in_rd;
         end
      end else begin
         main_v_d = enq;
         if (enq) begin
            main_data_d = in_data;
            main_rd_d   = in_rd;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_v_q    <= 1'b0;
         main_data_q <= '0;
         main_rd_q   <= '0;
         skid_v_q    <= 1'b0;
         skid_data_q <= '0;
         skid_rd_q   <= '0;
         flags_q     <= 4'b0000;
         skip_q      <= '0;
      end else begin
         main_v_q    <= main_v_d;
         main_data_q <= main_data_d;
         main_rd_q   <= main_rd_d;
         skid_v_q    <= skid_v_d;
         skid_data_q <= skid_data_d;
         skid_rd_q   <= skid_rd_d;
         flags_q     <= flags_d;
         skip_q      <= skip_d;
      end
   end
endmodule
